ctl_param_loader: RTL and testbench
===================================

// Module: ctl_param_loader
// PURPOSE
//  Polls the control-flag word (address 0x00) of the host-written controller BRAM. On each rising edge
//  of a group's set bit, burst-reads that group's register window into a staging buffer, then commits it
//  atomically to the group's shadow outputs with a one-cycle update strobe. Sits between the controller
//  BRAM and mod/STM/silencer/encoder/debug/sync consumers; generalises per-register latching to N groups.
// PARAMETERS
//  NUM_GROUPS   6                       number of load groups; group g is triggered by flag bit g
//  ADDR_W       8                       controller BRAM address width
//  DATA_W       16                      controller BRAM data width
//  MAX_REGS     16                      max registers per group (shadow slice depth)
//  RD_LATENCY   2                       BRAM read latency in cycles (1..4)
//  GROUP_BASE   {NUM_GROUPS{8'h00}}     packed ADDR_W-bit start address per group (group 0 in LSBs)
//  GROUP_LEN    {NUM_GROUPS{5'd1}}      packed $clog2(MAX_REGS+1)-bit register count per group
// PORTS
//  CLK         in   1                            system clock
//  RST_N       in   1                            asynchronous active-low reset
//  BRAM_EN     out  1                            read enable, high on every cycle an address is issued
//  BRAM_ADDR   out  ADDR_W                       read address
//  BRAM_DOUT   in   DATA_W                       read data, valid RD_LATENCY cycles after issue
//  CTL_FLAG    out  DATA_W                       last polled control-flag word
//  GRP_DATA    out  NUM_GROUPS*MAX_REGS*DATA_W   shadow regs; group g reg i at [(g*MAX_REGS+i)*DATA_W +: DATA_W]
//  GRP_UPDATE  out  NUM_GROUPS                   one-cycle strobe, bit g: group g shadow just committed
//  BUSY        out  1                            high in LOAD/DRAIN/COMMIT
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, prev_flag=0, pending=0, staging=0, state POLL_RD.
//  FSM:
//  - POLL_RD: issue addr 0x00 -> POLL_WAIT.
//  - POLL_WAIT: RD_LATENCY-1 cycles -> POLL_CHK.
//  - POLL_CHK: capture BRAM_DOUT into CTL_FLAG; rise = flag & ~prev_flag; prev_flag <= flag;
//    pending |= rise[NUM_GROUPS-1:0]. If new pending nonzero: g = lowest set index -> LOAD, else -> POLL_RD.
//  - LOAD: issue GROUP_BASE[g]+k for k=0..GROUP_LEN[g]-1, one per cycle, back-to-back -> DRAIN.
//  - DRAIN: remaining captures complete; data issued at cycle c lands in staging[k] at c+RD_LATENCY.
//  - COMMIT (1 cycle): GRP_DATA slice g <= staging[0..LEN-1], regs LEN..MAX_REGS-1 of slice <= 0;
//    GRP_UPDATE[g]=1 on the same edge; pending[g] cleared -> POLL_RD.
//  Latency: first LOAD address to GRP_UPDATE = GROUP_LEN+RD_LATENCY cycles. Slices of other groups never change.
//  Edge semantics: a bit held high loads once; must fall, be polled low, then rise again to reload.
//    A bit set at reset release produces a load on the first poll (prev_flag=0).
//  Simultaneous rises: queued in pending and served lowest index first, one group per COMMIT, with a
//    fresh poll between groups. Rises during LOAD are detected at the next poll and never lost,
//    provided the bit stays high across that poll.
//  Flag bits >= NUM_GROUPS (e.g. force-fan bit 13) only appear on CTL_FLAG.
//  GRP_UPDATE is never multi-hot. It is 0 outside COMMIT.
//  Reset mid-LOAD/DRAIN: staging discarded, no strobe, shadows 0. A set flag then reloads after release.
//  Elaboration $error: GROUP_LEN[g] == 0 or > MAX_REGS, or GROUP_BASE[g]+GROUP_LEN[g]-1 >= 2**ADDR_W.
//  Address arithmetic is ADDR_W bits, with no wrap permitted (guaranteed by the check above).
// TESTING
//  1 Reset with BRAM all 0 -> all outputs 0 and no GRP_UPDATE over 200 cycles.
//  2 Group0 base 0x22 len 10 (mem 0x22..0x2B = 0x1000+k), flag 0x0001 -> exactly one GRP_UPDATE[0];
//    slice0 regs 0..9 = 0x1000..0x1009, regs 10..15 = 0; first LOAD addr to strobe = 12 cycles.
//  3 Flag 0x0000 -> 0x0006 in one write -> GRP_UPDATE[1] then GRP_UPDATE[2] in separate cycles, group1 first.
//  4 Flag bit0 held high 1000 cycles -> one strobe. Clear, then set again -> second strobe with re-read data.
//  5 Set bit3 while group2 is in LOAD -> group2 commits; group3 commits after the next poll; no strobe lost.
//  6 RST_N low during group0 LOAD, flag left 0x0001 -> no strobe, outputs 0; after release one GRP_UPDATE[0].
//    Flag 0x2000 -> CTL_FLAG = 0x2000 and no GRP_UPDATE.

Source files
------------

// File: rtl/ctl_param_loader.sv
// Controller BRAM parameter loader: polls the flag word and, on each
// rising group flag, burst-reads that group's window into its shadow slice.
module ctl_param_loader #(
   parameter int NUM_GROUPS = 6,
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int MAX_REGS   = 16,
   parameter int RD_LATENCY = 2,
   parameter logic [NUM_GROUPS*ADDR_W-1:0] GROUP_BASE = {NUM_GROUPS{8'h00}},
   parameter logic [NUM_GROUPS*$clog2(MAX_REGS+1)-1:0] GROUP_LEN =
      {NUM_GROUPS{5'd1}}
) (
   input  logic                                  CLK,
   input  logic                                  RST_N,
   output logic                                  BRAM_EN,
   output logic [ADDR_W-1:0]                     BRAM_ADDR,
   input  logic [DATA_W-1:0]                     BRAM_DOUT,
   output logic [DATA_W-1:0]                     CTL_FLAG,
   output logic [NUM_GROUPS*MAX_REGS*DATA_W-1:0] GRP_DATA,
   output logic [NUM_GROUPS-1:0]                 GRP_UPDATE,
   output logic                                  BUSY
);

   localparam int LEN_W = $clog2(MAX_REGS+1);
   localparam int IDX_W = (MAX_REGS > 1) ? $clog2(MAX_REGS) : 1;
   localparam int GRP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
   localparam int TOT_W = NUM_GROUPS*MAX_REGS*DATA_W;
   localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY-1);

   localparam logic [2:0] POLL_RD   = 3'd0;
   localparam logic [2:0] POLL_WAIT = 3'd1;
   localparam logic [2:0] POLL_CHK  = 3'd2;
   localparam logic [2:0] LOAD      = 3'd3;
   localparam logic [2:0] DRAIN     = 3'd4;
   localparam logic [2:0] COMMIT    = 3'd5;

   if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_lat_err
      $error("ctl_param_loader: RD_LATENCY out of range");
   end

   for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_chk
      localparam int B = int'(GROUP_BASE[g*ADDR_W +: ADDR_W]);
      localparam int N = int'(GROUP_LEN[g*LEN_W +: LEN_W]);
      if (N == 0 || N > MAX_REGS) begin : g_len_err
         $error("ctl_param_loader: bad GROUP_LEN");
      end
      if (B + N - 1 >= (1 << ADDR_W)) begin : g_addr_err
         $error("ctl_param_loader: group window exceeds address space");
      end
   end

   logic [2:0]            state_q, state_d;
   logic                  run_q;
   logic [1:0]            wait_q, wait_d;
   logic [LEN_W-1:0]      ld_cnt_q, ld_cnt_d;
   logic [LEN_W-1:0]      cap_q, cap_d;
   logic [GRP_W-1:0]      grp_q, grp_d;
   logic [NUM_GROUPS-1:0] pend_q, pend_d;
   logic [NUM_GROUPS-1:0] prev_q, prev_d;
   logic [NUM_GROUPS-1:0] pend_new;
   logic [DATA_W-1:0]     flag_q, flag_d;
   logic [RD_LATENCY-1:0] pipe_q, pipe_d;
   logic [DATA_W-1:0]     stg_q [MAX_REGS];
   logic [DATA_W-1:0]     stg_d [MAX_REGS];
   logic [TOT_W-1:0]      data_q, data_d;
   logic [NUM_GROUPS-1:0] upd_q, upd_d;
   logic [ADDR_W-1:0]     cur_base;
   logic [LEN_W-1:0]      cur_len;
   logic                  issue_ld;
   logic                  capture;

   assign cur_base = GROUP_BASE[int'(grp_q)*ADDR_W +: ADDR_W];
   assign cur_len  = GROUP_LEN[int'(grp_q)*LEN_W +: LEN_W];
   assign issue_ld = run_q && (state_q == LOAD);
   assign capture  = pipe_q[RD_LATENCY-1];

   // Read port: poll address 0 or the current group window; held off
   // until the first clock after reset release.
   always_comb begin
      BRAM_EN   = 1'b0;
      BRAM_ADDR = '0;
      if (run_q && state_q == POLL_RD) begin
         BRAM_EN = 1'b1;
      end else if (issue_ld) begin
         BRAM_EN   = 1'b1;
         BRAM_ADDR = cur_base + ADDR_W'(ld_cnt_q);
      end
   end

   assign CTL_FLAG   = flag_q;
   assign GRP_DATA   = data_q;
   assign GRP_UPDATE = upd_q;
   assign BUSY       = (state_q == LOAD) || (state_q == DRAIN) ||
                       (state_q == COMMIT);

   // Poll / load / commit sequencer with read-return tracking.
   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      ld_cnt_d = ld_cnt_q;
      cap_d    = cap_q;
      grp_d    = grp_q;
      pend_d   = pend_q;
      prev_d   = prev_q;
      flag_d   = flag_q;
      data_d   = data_q;
      upd_d    = '0;
      stg_d    = stg_q;
      pend_new = pend_q | (BRAM_DOUT[NUM_GROUPS-1:0] & ~prev_q);
      pipe_d   = RD_LATENCY'({pipe_q, issue_ld});

      if (capture) begin
         stg_d[IDX_W'(cap_q)] = BRAM_DOUT;
         cap_d = cap_q + 1'b1;
      end

      unique case (state_q)
         POLL_RD: begin
            if (run_q) begin
               state_d = (RD_LATENCY > 1) ? POLL_WAIT : POLL_CHK;
               wait_d  = WAIT_INIT;
            end
         end
         POLL_WAIT: begin
            if (wait_q == 2'd1) state_d = POLL_CHK;
            else                wait_d  = wait_q - 2'd1;
         end
         POLL_CHK: begin
            flag_d = BRAM_DOUT;
            prev_d = BRAM_DOUT[NUM_GROUPS-1:0];
            pend_d = pend_new;
            if (|pend_new) begin
               for (int g = NUM_GROUPS-1; g >= 0; g--) begin
                  if (pend_new[g]) grp_d = GRP_W'(g);
               end
               ld_cnt_d = '0;
               cap_d    = '0;
               state_d  = LOAD;
            end else begin
               state_d = POLL_RD;
            end
         end
         LOAD: begin
            ld_cnt_d = ld_cnt_q + 1'b1;
            if (ld_cnt_q == cur_len - 1'b1) begin
               state_d = (RD_LATENCY > 1) ? DRAIN : COMMIT;
               wait_d  = WAIT_INIT;
            end
         end
         DRAIN: begin
            if (wait_q == 2'd1) state_d = COMMIT;
            else                wait_d  = wait_q - 2'd1;
         end
         COMMIT: begin
            // Last word returns this cycle, so read from stg_d.
            for (int i = 0; i < MAX_REGS; i++) begin
               data_d[(int'(grp_q)*MAX_REGS+i)*DATA_W +: DATA_W] =
                  (i < int'(cur_len)) ? stg_d[i] : '0;
            end
            upd_d[grp_q]  = 1'b1;
            pend_d[grp_q] = 1'b0;
            state_d       = POLL_RD;
         end
         default: state_d = POLL_RD;
      endcase
   end

   // State registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= POLL_RD;
         run_q    <= 1'b0;
         wait_q   <= '0;
         ld_cnt_q <= '0;
         cap_q    <= '0;
         grp_q    <= '0;
         pend_q   <= '0;
         prev_q   <= '0;
         flag_q   <= '0;
         pipe_q   <= '0;
         data_q   <= '0;
         upd_q    <= '0;
         for (int i = 0; i < MAX_REGS; i++) stg_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         run_q    <= 1'b1;
         wait_q   <= wait_d;
         ld_cnt_q <= ld_cnt_d;
         cap_q    <= cap_d;
         grp_q    <= grp_d;
         pend_q   <= pend_d;
         prev_q   <= prev_d;
         flag_q   <= flag_d;
         pipe_q   <= pipe_d;
         data_q   <= data_d;
         upd_q    <= upd_d;
         stg_q    <= stg_d;
      end
   end

endmodule

// File: tb/tb_ctl_param_loader.sv
// Directed bench for ctl_param_loader with a 2-cycle BRAM model.
// Expected values are hand-derived from the memory image below.
module tb_ctl_param_loader;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          bram_en;
   logic [7:0]    bram_addr;
   logic [15:0]   bram_dout;
   logic [15:0]   ctl_flag;
   logic [1535:0] grp_data;
   logic [5:0]    grp_update;
   logic          busy;

   logic [15:0] mem [256];
   logic [15:0] r1 = '0;
   logic [15:0] r2 = '0;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int upd_cnt [6] = '{0, 0, 0, 0, 0, 0};
   int tot = 0;
   int nmulti = 0;
   int ld_cyc = -1;
   int up_cyc = 0;
   int order [$];

   ctl_param_loader #(
      .NUM_GROUPS(6), .ADDR_W(8), .DATA_W(16), .MAX_REGS(16),
      .RD_LATENCY(2),
      .GROUP_BASE({8'hF0, 8'h80, 8'h70, 8'h50, 8'h40, 8'h22}),
      .GROUP_LEN({5'd16, 5'd1, 5'd2, 5'd16, 5'd3, 5'd10})
   ) dut (
      .CLK(clk), .RST_N(rst_n),
      .BRAM_EN(bram_en), .BRAM_ADDR(bram_addr), .BRAM_DOUT(bram_dout),
      .CTL_FLAG(ctl_flag), .GRP_DATA(grp_data),
      .GRP_UPDATE(grp_update), .BUSY(busy)
   );

   always #5 clk = ~clk;

   // Two-stage synchronous read: data valid 2 cycles after issue.
   always @(posedge clk) begin
      if (bram_en) r1 <= mem[bram_addr];
      r2 <= r1;
      cyc <= cyc + 1;
   end
   assign bram_dout = r2;

   // Strobe monitor.
   always @(negedge clk) begin
      if (grp_update != '0) begin
         if ($countones(grp_update) != 1) nmulti++;
         for (int g = 0; g < 6; g++) begin
            if (grp_update[g]) begin
               upd_cnt[g]++;
               tot++;
               order.push_back(g);
               up_cyc = cyc;
            end
         end
      end
      if (bram_en && bram_addr == 8'h22 && ld_cyc < 0) ld_cyc = cyc;
   end

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_upd(input int g, input int n, input int budget,
                           input string tag);
      int k;
      k = 0;
      while (upd_cnt[g] < n && k < budget) begin
         tick();
         k++;
      end
      chk(tag, upd_cnt[g], n);
   endtask

   task automatic wait_addr(input logic [7:0] a, input int budget,
                            input string tag);
      int k;
      bit seen;
      k = 0;
      seen = 0;
      while (!seen && k < budget) begin
         tick();
         if (bram_en && bram_addr == a) seen = 1;
         k++;
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   function automatic logic [15:0] rg(input int g, input int i);
      return grp_data[(g*16+i)*16 +: 16];
   endfunction

   initial begin
      int s;
      int t0;
      for (int a = 0; a < 256; a++) mem[a] = '0;

      // 1: reset and idle with empty memory
      ticks(5);
      chk("t1_rst_en", 32'(bram_en), 0);
      chk("t1_rst_addr", 32'(bram_addr), 0);
      chk("t1_rst_upd", 32'(grp_update), 0);
      chk("t1_rst_busy", 32'(busy), 0);
      chk("t1_rst_data", 32'(|grp_data), 0);
      rst_n = 1'b1;
      ticks(200);
      chk("t1_nostb", tot, 0);
      chk("t1_flag", 32'(ctl_flag), 0);
      chk("t1_data", 32'(|grp_data), 0);

      for (int a = 1; a < 256; a++) mem[a] = 16'hA000 | 16'(a);
      for (int k = 0; k < 10; k++) mem[8'h22 + k] = 16'h1000 + 16'(k);

      // 2: group 0 load, contents and latency
      mem[0] = 16'h0001;
      wait_upd(0, 1, 300, "t2_stb");
      chk("t2_lat", up_cyc - ld_cyc, 12);
      for (int i = 0; i < 16; i++)
         chk($sformatf("t2_r%0d", i), 32'(rg(0, i)),
             (i < 10) ? 32'h1000 + 32'(i) : 32'h0);
      ticks(20);
      chk("t2_once", upd_cnt[0], 1);
      chk("t2_tot", tot, 1);

      // 4: held flag loads once; re-arm reloads new data
      ticks(1000);
      chk("t4_held", upd_cnt[0], 1);
      mem[0] = 16'h0000;
      ticks(20);
      for (int k = 0; k < 10; k++) mem[8'h22 + k] = 16'h2000 + 16'(k);
      mem[0] = 16'h0001;
      wait_upd(0, 2, 300, "t4_stb2");
      chk("t4_r0", 32'(rg(0, 0)), 32'h2000);
      chk("t4_r9", 32'(rg(0, 9)), 32'h2009);
      mem[0] = 16'h0000;
      ticks(20);

      // 3: simultaneous rises served lowest first
      s = order.size();
      mem[0] = 16'h0006;
      wait_upd(2, 1, 400, "t3_g2");
      chk("t3_g1", upd_cnt[1], 1);
      chk("t3_n", order.size(), s + 2);
      chk("t3_first", order[s], 1);
      chk("t3_second", order[s+1], 2);
      chk("t3_g1r0", 32'(rg(1, 0)), 32'hA040);
      chk("t3_g1r2", 32'(rg(1, 2)), 32'hA042);
      chk("t3_g1r3", 32'(rg(1, 3)), 32'h0);
      chk("t3_g0keep", 32'(rg(0, 0)), 32'h2000);
      mem[0] = 16'h0000;
      ticks(20);

      // 5: rise during another group's LOAD is not lost
      s = order.size();
      mem[0] = 16'h0004;
      wait_addr(8'h55, 200, "t5_inload");
      mem[0] = 16'h000C;
      wait_upd(3, 1, 400, "t5_g3");
      chk("t5_g2", upd_cnt[2], 2);
      chk("t5_first", order[s], 2);
      chk("t5_second", order[s+1], 3);
      chk("t5_g3r1", 32'(rg(3, 1)), 32'hA071);
      chk("t5_g2r15", 32'(rg(2, 15)), 32'hA05F);
      mem[0] = 16'h0000;
      ticks(20);

      // 6: reset in the middle of a load
      mem[0] = 16'h0001;
      wait_addr(8'h24, 200, "t6_inload");
      t0 = tot;
      rst_n = 1'b0;
      ticks(3);
      chk("t6_rst_en", 32'(bram_en), 0);
      chk("t6_rst_data", 32'(|grp_data), 0);
      chk("t6_rst_flag", 32'(ctl_flag), 0);
      rst_n = 1'b1;
      chk("t6_nostb", tot, t0);
      wait_upd(0, 3, 300, "t6_reload");
      chk("t6_tot", tot, t0 + 1);
      chk("t6_r0", 32'(rg(0, 0)), 32'h2000);
      chk("t6_g1z", 32'(rg(1, 0)), 32'h0);

      // 7: non-group bit only reaches CTL_FLAG
      t0 = tot;
      mem[0] = 16'h2000;
      ticks(50);
      chk("t7_flag", 32'(ctl_flag), 32'h2000);
      chk("t7_nostb", tot, t0);

      // 8: highest group, full-length window ending at 0xFF
      mem[0] = 16'h2020;
      wait_upd(5, 1, 300, "t8_g5");
      chk("t8_r0", 32'(rg(5, 0)), 32'hA0F0);
      chk("t8_r15", 32'(rg(5, 15)), 32'hA0FF);

      chk("multihot", nmulti, 0);
      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

endmodule
